// File: rtl/norm_frame_serializer_pkg.sv
// Shared widths for the normalizer result bus and the serialized AXIS beat.
package norm_frame_serializer_pkg;

   localparam int CH_NUM_DEF = 11;
   localparam int DW_DEF     = 32;
   localparam int TUSER_W    = 4;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_SHIFT = 1'b1
   } hold_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_wide.sv
// Wide-word synchronous FIFO, show-ahead read, synchronous flush.
module sync_fifo_wide
   import norm_frame_serializer_pkg::*;
#(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         wr_en_i,
   input  logic [W-1:0] wr_data_i,
   input  logic         rd_en_i,
   output logic [W-1:0] rd_data_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_ptr_q;
   logic [AW:0]  rd_ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_en_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (rd_en_i) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage needs no reset; only entries behind the write pointer are ever read.
   always_ff @(posedge clk) begin
      if (wr_en_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/norm_frame_serializer.sv
// Buffers wide normalizer words and serializes them one channel per AXIS beat,
// framing every CNT words with tlast.
//   state    | meaning
//   ST_EMPTY | holding register empty, waiting for a FIFO word
//   ST_SHIFT | holding register loaded, presenting channel ch_idx_q
module norm_frame_serializer
   import norm_frame_serializer_pkg::*;
#(
   parameter int CH_NUM     = CH_NUM_DEF,
   parameter int DW         = DW_DEF,
   parameter int CNT        = 1000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_flag,
   input  logic [CH_NUM*DW-1:0] data_in,
   input  logic                 data_in_valid,
   output logic [DW-1:0]        m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tlast,
   output logic [TUSER_W-1:0]   m_axis_tuser,
   output logic                 overflow,
   output logic                 frame_done,
   output logic                 busy
);

   localparam int SMP_W = clog2(CNT);
   localparam logic [TUSER_W-1:0] LAST_CH  = TUSER_W'(CH_NUM - 1);
   localparam logic [SMP_W-1:0]   LAST_SMP = SMP_W'(CNT - 1);

   hold_state_e            state_q, state_d;
   logic [CH_NUM*DW-1:0]   hold_q, hold_d;
   logic [TUSER_W-1:0]     ch_idx_q, ch_idx_d;
   logic [SMP_W-1:0]       smp_cnt_q, smp_cnt_d;
   logic                   ovf_q, ovf_d;

   logic [CH_NUM*DW-1:0]   fifo_rd_data;
   logic                   fifo_full, fifo_empty;
   logic                   pop, push, hs, last_ch;

   sync_fifo_wide #(.W(CH_NUM*DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_i   (start_flag),
      .wr_en_i   (push),
      .wr_data_i (data_in),
      .rd_en_i   (pop),
      .rd_data_o (fifo_rd_data),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign m_axis_tvalid = (state_q == ST_SHIFT);
   assign m_axis_tuser  = ch_idx_q;
   assign last_ch       = (ch_idx_q == LAST_CH);
   assign m_axis_tlast  = m_axis_tvalid && last_ch && (smp_cnt_q == LAST_SMP);
   assign hs            = m_axis_tvalid && m_axis_tready;
   assign frame_done    = hs && m_axis_tlast;
   assign overflow      = ovf_q;
   assign busy          = !fifo_empty || (state_q == ST_SHIFT);

   // Channel 0 sits in the MSB slice of the word.
   always_comb begin
      m_axis_tdata = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         if (ch_idx_q == TUSER_W'(c)) m_axis_tdata = hold_q[(CH_NUM-1-c)*DW +: DW];
      end
   end

   // A full FIFO still accepts a word when the same edge pops one.
   assign push = data_in_valid && !start_flag && (!fifo_full || pop);

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      ch_idx_d  = ch_idx_q;
      smp_cnt_d = smp_cnt_q;
      ovf_d     = ovf_q;
      pop       = 1'b0;
      if (start_flag) begin
         state_d   = ST_EMPTY;
         hold_d    = '0;
         ch_idx_d  = '0;
         smp_cnt_d = '0;
         ovf_d     = 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (!fifo_empty) begin
                  pop      = 1'b1;
                  hold_d   = fifo_rd_data;
                  ch_idx_d = '0;
                  state_d  = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (hs && !last_ch) begin
                  ch_idx_d = ch_idx_q + TUSER_W'(1);
               end else if (hs) begin
                  smp_cnt_d = m_axis_tlast ? '0 : smp_cnt_q + SMP_W'(1);
                  ch_idx_d  = '0;
                  if (!fifo_empty) begin
                     pop    = 1'b1;
                     hold_d = fifo_rd_data;
                  end else begin
                     state_d = ST_EMPTY;
                  end
               end
            end
            default: state_d = ST_EMPTY;
         endcase
         if (data_in_valid && fifo_full && !pop) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         hold_q    <= '0;
         ch_idx_q  <= '0;
         smp_cnt_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         ch_idx_q  <= ch_idx_d;
         smp_cnt_q <= smp_cnt_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_norm_frame_serializer.sv
// Directed bench for norm_frame_serializer with a short frame (CNT = 3).
module tb_norm_frame_serializer;

   localparam int CH  = 11;
   localparam int DW  = 32;
   localparam int CNT = 3;

   logic             clk;
   logic             rst_n;
   logic             start_flag;
   logic [CH*DW-1:0] data_in;
   logic             data_in_valid;
   logic [DW-1:0]    m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic             m_axis_tlast;
   logic [3:0]       m_axis_tuser;
   logic             overflow;
   logic             frame_done;
   logic             busy;

   norm_frame_serializer #(.CH_NUM(CH), .DW(DW), .CNT(CNT), .FIFO_DEPTH(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_flag    (start_flag),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .overflow      (overflow),
      .frame_done    (frame_done),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];
   int          mdl_ch;
   int          mdl_smp;

   typedef struct {
      logic        vld;
      logic        e_tvalid;
      logic [31:0] e_tdata;
      logic [3:0]  e_tuser;
      logic        e_busy;
   } vec_t;

   vec_t vecs[13];

   function automatic logic [CH*DW-1:0] mk_word(input logic [31:0] base);
      logic [CH*DW-1:0] w;
      for (int c = 0; c < CH; c++) w[(CH-1-c)*DW +: DW] = base + 32'(c);
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      start_flag    = 1'b0;
      data_in_valid = 1'b0;
      data_in       = '0;
      m_axis_tready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      mdl_ch  = 0;
      mdl_smp = 0;
   endtask

   task automatic push_words(input logic [31:0] base0, input int n, input int keep);
      for (int i = 0; i < n; i++) begin
         data_in_valid = 1'b1;
         data_in       = mk_word(base0 + 32'(i * 256));
         if (i < keep) exp_q.push_back(base0 + 32'(i * 256));
         tick();
      end
      data_in_valid = 1'b0;
   endtask

   // Consumes beats against the model queue; the model only advances on a handshake,
   // so any change of tdata/tuser/tlast during a stall is caught.
   task automatic drain(input string tag, input int nbeats, input int stall_pct,
                        input bit contig, input int max_cyc);
      int   got;
      int   gaps;
      int   cyc;
      bit   seen;
      logic stall;
      logic exp_last;
      got = 0; gaps = 0; cyc = 0; seen = 1'b0;
      while (got < nbeats && cyc < max_cyc) begin
         stall = (stall_pct > 0) &&
                 ((cyc < 3) ? (cyc == 1) : (int'($urandom_range(99)) < stall_pct));
         m_axis_tready = !stall;
         #1;
         if (m_axis_tvalid) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL %s extra beat: got tdata %h, no beat expected", tag, m_axis_tdata);
            end else begin
               exp_last = (mdl_ch == CH-1) && (mdl_smp == CNT-1);
               chk({tag, " tdata"}, m_axis_tdata, exp_q[0] + 32'(mdl_ch));
               chk({tag, " tuser"}, 32'(m_axis_tuser), 32'(mdl_ch));
               chk({tag, " tlast"}, 32'(m_axis_tlast), 32'(exp_last));
               chk({tag, " frame_done"}, 32'(frame_done), 32'(exp_last && !stall));
               if (!stall) begin
                  got++;
                  if (mdl_ch == CH-1) begin
                     mdl_ch  = 0;
                     void'(exp_q.pop_front());
                     mdl_smp = (mdl_smp == CNT-1) ? 0 : mdl_smp + 1;
                  end else begin
                     mdl_ch++;
                  end
               end
            end
         end else if (seen) begin
            gaps++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, " beats"}, 32'(got), 32'(nbeats));
      if (contig) chk({tag, " gaps"}, 32'(gaps), 32'd0);
   endtask

   initial begin
      bit found;

      for (int k = 0; k < 13; k++) begin
         vecs[k].vld      = (k == 0);
         vecs[k].e_tvalid = (k >= 1 && k <= 11);
         vecs[k].e_tdata  = (k >= 1 && k <= 11) ? 32'h1000_0000 + 32'(k - 1) : 32'h0;
         vecs[k].e_tuser  = (k >= 1 && k <= 11) ? 4'(k - 1) : 4'd0;
         vecs[k].e_busy   = (k <= 11);
      end

      // Scenario 1: reset state, then one word with cycle-exact timing
      do_reset();
      chk("rst tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst tdata", m_axis_tdata, 32'd0);
      chk("rst tuser", 32'(m_axis_tuser), 32'd0);
      chk("rst tlast", 32'(m_axis_tlast), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst overflow", 32'(overflow), 32'd0);
      chk("rst frame_done", 32'(frame_done), 32'd0);
      for (int k = 0; k < 13; k++) begin
         data_in_valid = vecs[k].vld;
         data_in       = mk_word(32'h1000_0000);
         m_axis_tready = 1'b1;
         tick();
         chk($sformatf("s1[%0d] tvalid", k), 32'(m_axis_tvalid), 32'(vecs[k].e_tvalid));
         if (vecs[k].e_tvalid) begin
            chk($sformatf("s1[%0d] tdata", k), m_axis_tdata, vecs[k].e_tdata);
            chk($sformatf("s1[%0d] tuser", k), 32'(m_axis_tuser), 32'(vecs[k].e_tuser));
         end
         chk($sformatf("s1[%0d] tlast", k), 32'(m_axis_tlast), 32'd0);
         chk($sformatf("s1[%0d] frame_done", k), 32'(frame_done), 32'd0);
         chk($sformatf("s1[%0d] busy", k), 32'(busy), 32'(vecs[k].e_busy));
      end
      data_in_valid = 1'b0;

      // Scenario 2: three words back-to-back form one frame, fourth starts a new one
      do_reset();
      push_words(32'h2000_0000, 3, 3);
      drain("s2", 33, 0, 1'b1, 100);
      m_axis_tready = 1'b0;
      push_words(32'h2000_0300, 1, 1);
      drain("s2b", 11, 0, 1'b1, 60);

      // Scenario 3: stalls must hold every beat
      do_reset();
      push_words(32'h1000_0000, 1, 1);
      drain("s3", 11, 20, 1'b0, 300);
      chk("s3 busy end", 32'(busy), 32'd0);

      // Scenario 4: overflow with tready low, then exactly five words drain
      do_reset();
      push_words(32'h4000_0000, 5, 5);
      chk("s4 overflow pre", 32'(overflow), 32'd0);
      chk("s4 busy", 32'(busy), 32'd1);
      push_words(32'h4000_0500, 1, 0);
      chk("s4 overflow set", 32'(overflow), 32'd1);
      tick();
      tick();
      chk("s4 overflow sticky", 32'(overflow), 32'd1);
      drain("s4", 55, 0, 1'b1, 120);
      tick();
      tick();
      chk("s4 no extra tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("s4 busy end", 32'(busy), 32'd0);
      chk("s4 overflow after drain", 32'(overflow), 32'd1);

      // Scenario 5: start_flag aborts mid-word and clears overflow
      do_reset();
      push_words(32'h5000_0000, 6, 0);
      chk("s5 overflow pre", 32'(overflow), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         m_axis_tready = 1'b1;
         #1;
         if (m_axis_tvalid && m_axis_tdata == 32'h5000_0105) found = 1'b1;
         else tick();
      end
      chk("s5 reached word1 ch5", 32'(found), 32'd1);
      start_flag    = 1'b1;
      data_in_valid = 1'b1;
      data_in       = mk_word(32'h5555_0000);
      tick();
      start_flag    = 1'b0;
      data_in_valid = 1'b0;
      chk("s5 tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("s5 overflow", 32'(overflow), 32'd0);
      chk("s5 busy", 32'(busy), 32'd0);
      chk("s5 tuser", 32'(m_axis_tuser), 32'd0);
      tick();
      tick();
      chk("s5 discarded word", 32'(m_axis_tvalid), 32'd0);
      chk("s5 busy later", 32'(busy), 32'd0);
      exp_q.delete();
      mdl_ch  = 0;
      mdl_smp = 0;
      m_axis_tready = 1'b0;
      push_words(32'h6000_0000, 3, 3);
      drain("s5", 33, 0, 1'b1, 100);

      // Scenario 6: asynchronous reset mid-beat
      do_reset();
      push_words(32'h7000_0000, 6, 0);
      m_axis_tready = 1'b1;
      tick();
      tick();
      chk("s6 overflow pre", 32'(overflow), 32'd1);
      chk("s6 tvalid pre", 32'(m_axis_tvalid), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("s6 tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("s6 tdata", m_axis_tdata, 32'd0);
      chk("s6 tuser", 32'(m_axis_tuser), 32'd0);
      chk("s6 tlast", 32'(m_axis_tlast), 32'd0);
      chk("s6 busy", 32'(busy), 32'd0);
      chk("s6 overflow", 32'(overflow), 32'd0);
      chk("s6 frame_done", 32'(frame_done), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/norm_frame_serializer.md
Name: norm_frame_serializer

Overview:
- Downstream consumer of the FIR/normalizer output bus.
- Accepts packed wide result words: CH_NUM channels of DW bits, with a valid strobe and no backpressure.
- Buffers the words in a small FIFO and serializes them one channel per beat onto an AXI-Stream-style master port for the DMA/UART path.
- Frames the stream: tlast marks the final beat of every CNT-sample frame.

Parameters:
- CH_NUM, 11, channels per input word.
- DW, 32, bits per channel.
- CNT, 1000, input words (samples) per frame.
- FIFO_DEPTH, 4, wide-word FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start_flag  in  1  one-cycle pulse; synchronous flush and frame restart.
- data_in  in  CH_NUM*DW  packed word; ch0 = MSB slice [CH_NUM*DW-1 -: DW].
- data_in_valid  in  1  word strobe; one word per high cycle.
- m_axis_tdata  out  DW  current channel sample.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tuser  out  4  channel index of the current beat (0..CH_NUM-1).
- overflow  out  1  sticky: an input word was dropped.
- frame_done  out  1  one-cycle pulse on the tlast handshake.
- busy  out  1  FIFO non-empty or holding register loaded.

Behaviour:
- Reset (async): FIFO empty, pointers 0, holding register empty, ch_idx = 0, smp_cnt = 0. All outputs 0.
- Write side:
  - data_in_valid and FIFO not full: write the word at the edge.
  - FIFO full and a pop happens the same cycle: write proceeds.
  - FIFO full and no pop: drop the word and set overflow (sticky).
- overflow clears only on rst_n or start_flag.
- Holding register (wide) with states EMPTY / SHIFT:
  - EMPTY: if the FIFO is non-empty, pop into the holding register, set ch_idx = 0, go to SHIFT.
  - SHIFT: tvalid = 1, tdata = slice ch_idx, tuser = ch_idx.
  - On a handshake (tvalid & tready) with ch_idx < CH_NUM-1: ch_idx++.
  - On a handshake with ch_idx = CH_NUM-1: smp_cnt++. If the FIFO is non-empty, pop and reload the same cycle with ch_idx = 0 and stay in SHIFT (back-to-back, no bubble). Otherwise go to EMPTY.
- Latency: word written at edge t (FIFO was empty, holding EMPTY) → popped at t+1 → tvalid high after edge t+1 (first beat visible the cycle after write).
- Sustained throughput: one beat per cycle with tready held high, so one word per CH_NUM cycles. Input faster than this fills the FIFO and then overflows.
- Stability: tdata, tuser and tlast are held while tvalid & !tready.
- tlast = (ch_idx = CH_NUM-1) && (smp_cnt = CNT-1).
- On the tlast handshake: smp_cnt wraps to 0 and frame_done pulses the same cycle.
- smp_cnt width: clog2(CNT), with CNT ≥ 2.
- start_flag (synchronous, highest priority after reset):
  - Empties the FIFO and holding register.
  - Zeroes ch_idx, smp_cnt and overflow.
  - tvalid drops the next cycle, even mid-beat. This is an intentional abort.
  - A data_in_valid in the same cycle as start_flag is discarded.
- Simultaneous push and pop when the FIFO is not full: both occur; the occupancy count is unchanged.
- Reset mid-frame: all state lost; there is no partial-frame recovery.

Decomposition:
- Shared package: CH_NUM/DW defaults (shared with the normalizer bus width), a clog2 function, and an AXIS beat-struct-equivalent localparams for tuser width.
- Sub-module: sync_fifo_wide (width CH_NUM*DW, depth FIFO_DEPTH, full/empty, registered write, show-ahead read). Holding/shift FSM and counters stay in the top.

Test Plan:
1. Reset, then one word with ch k = 32'h1000_0000+k, tready = 1 → tvalid from cycle 1 after write; 11 beats with tdata 0x1000_0000..0x1000_000A, tuser 0..10; tlast = 0; busy drops after beat 10.
2. CNT = 3 override; 3 words back-to-back, tready = 1 → 33 contiguous beats; tlast and frame_done only on beat 33 (ch 10 of word 2); 4th word restarts smp_cnt at 0.
3. tready toggled 1-0-1 pattern with a random 20% stall → tdata/tuser held during every stall; beat order and values identical to scenario 1.
4. tready = 0; 6 words pushed on consecutive cycles (FIFO_DEPTH = 4, one in holding) → words 1–5 kept, word 6 dropped, overflow = 1 and sticky; releasing tready yields exactly 55 beats.
5. start_flag mid-frame at beat 5 of word 2 → next cycle tvalid = 0, overflow = 0, busy = 0; a new word then emits ch0 with smp_cnt = 0 and tlast after CNT words.
6. rst_n asserted asynchronously mid-beat → all outputs 0 immediately, without waiting for a clock edge.
